imuldiv_div_client: RTL and testbench

Initiator-side adapter for the iterative divide unit: accepts one divide/remainder operation at a time from the issue stage and drives the divider's `divreq` val/rdy request port. It collects the 64-bit `{remainder, quotient}` response, selects the requested half, and presents it with its destination tag on a val/rdy writeback port. It sits between the integer pipeline's muldiv issue logic and the divider. At most one request is outstanding.

---
 rtl/imuldiv_div_client.sv | 132 +++++++++++++
 tb/tb_imuldiv_div_client.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imuldiv_div_client.sv
// Issue-side client of the iterative divider: one op in flight, returns the selected
// quotient/remainder half with its tag. Optional macro: IMULDIV_DIV_CLIENT_DIVZERO_EN.
module imuldiv_div_client #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_val,
   output logic             op_rdy,
   input  logic             op_fn,
   input  logic             op_sel,
   input  logic [TAG_W-1:0] op_tag,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   output logic             divreq_msg_fn,
   output logic [31:0]      divreq_msg_a,
   output logic [31:0]      divreq_msg_b,
   output logic             divreq_val,
   input  logic             divreq_rdy,
   input  logic [63:0]      divresp_msg_result,
   input  logic             divresp_val,
   output logic             divresp_rdy,
   output logic             wb_val,
   input  logic             wb_rdy,
   output logic [TAG_W-1:0] wb_tag,
   output logic [31:0]      wb_data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_WB    = 2'd3;

   logic [1:0] state_r;
   logic [1:0] state_nxt_s;
   logic       sel_r;
   logic       op_acc_s;
   logic       resp_cap_s;
   logic       op_zero_s;

   assign op_acc_s   = (state_r == ST_IDLE) && op_val;
   assign resp_cap_s = (state_r == ST_WAIT) && divresp_val;

`ifdef IMULDIV_DIV_CLIENT_DIVZERO_EN
   assign op_zero_s = (op_b == 32'd0);
`else
   assign op_zero_s = 1'b0;
`endif

   // Next-state decode; stale responses in ISSUE are drained without being captured
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (op_val) begin
               if (op_zero_s) begin
                  state_nxt_s = ST_WB;
               end else begin
                  state_nxt_s = ST_ISSUE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (divreq_rdy) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (divresp_val) begin
               state_nxt_s = ST_WB;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_WB: begin
            if (wb_rdy) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WB;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register with handshake outputs registered from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         op_rdy      <= 1'b1;
         divreq_val  <= 1'b0;
         divresp_rdy <= 1'b0;
         wb_val      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         op_rdy      <= (state_nxt_s == ST_IDLE);
         divreq_val  <= (state_nxt_s == ST_ISSUE);
         divresp_rdy <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_WAIT);
         wb_val      <= (state_nxt_s == ST_WB);
      end
   end

   // Operand capture on accept, result capture on the single-cycle response
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         divreq_msg_fn <= 1'b0;
         divreq_msg_a  <= 32'd0;
         divreq_msg_b  <= 32'd0;
         sel_r         <= 1'b0;
         wb_tag        <= {TAG_W{1'b0}};
         wb_data       <= 32'd0;
      end else begin
         if (op_acc_s) begin
            divreq_msg_fn <= op_fn;
            divreq_msg_a  <= op_a;
            divreq_msg_b  <= op_b;
            sel_r         <= op_sel;
            wb_tag        <= op_tag;
            if (op_zero_s) begin
               wb_data <= op_sel ? op_a : 32'hFFFF_FFFF;
            end
         end else if (resp_cap_s) begin
            wb_data <= sel_r ? divresp_msg_result[63:32] : divresp_msg_result[31:0];
         end
      end
   end

endmodule

// File: tb/tb_imuldiv_div_client.sv
// Self-checking bench for imuldiv_div_client: directed table, hand sequences and random ops
// against a behavioural divider stand-in and an arithmetic reference.
module tb_imuldiv_div_client;
   localparam int TAG_W = 5;
`ifdef IMULDIV_DIV_CLIENT_DIVZERO_EN
   localparam bit DZ = 1'b1;
`else
   localparam bit DZ = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             op_val, op_rdy, op_fn, op_sel;
   logic [TAG_W-1:0] op_tag;
   logic [31:0]      op_a, op_b;
   logic             divreq_msg_fn;
   logic [31:0]      divreq_msg_a, divreq_msg_b;
   logic             divreq_val, divreq_rdy;
   logic [63:0]      divresp_msg_result;
   logic             divresp_val, divresp_rdy;
   logic             wb_val, wb_rdy;
   logic [TAG_W-1:0] wb_tag;
   logic [31:0]      wb_data;

   always #5 clk = ~clk;

   imuldiv_div_client #(.TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .op_val(op_val), .op_rdy(op_rdy), .op_fn(op_fn), .op_sel(op_sel),
      .op_tag(op_tag), .op_a(op_a), .op_b(op_b),
      .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
      .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
      .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
      .divresp_rdy(divresp_rdy),
      .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_tag(wb_tag), .wb_data(wb_data)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference divide: {remainder, quotient}, RISC-V style for zero divisor and overflow
   function automatic logic [63:0] div_ref(input logic fn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (fn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Divider stand-in: 33-cycle latency, advances only while divresp_rdy is high, parks a response
   logic req_en = 1'b1;
   logic dv_busy = 1'b0;
   logic dv_pend = 1'b0;
   int   dv_cnt = 0;
   logic [63:0] dv_res = 64'd0;
   assign divreq_rdy         = req_en && !dv_busy;
   assign divresp_val        = dv_pend;
   assign divresp_msg_result = dv_res;

   always @(posedge clk) begin
      if (dv_pend) begin
         if (divresp_rdy) begin
            dv_pend <= 1'b0;
            dv_busy <= 1'b0;
         end
      end else if (dv_busy) begin
         if (divresp_rdy) begin
            if (dv_cnt == 1) dv_pend <= 1'b1;
            dv_cnt <= dv_cnt - 1;
         end
      end else if (divreq_val && divreq_rdy) begin
         dv_busy <= 1'b1;
         dv_cnt  <= 32;
         dv_res  <= div_ref(divreq_msg_fn, divreq_msg_a, divreq_msg_b);
      end
   end

   task automatic run_op(input string name, input logic fn, input logic sel,
                         input logic [TAG_W-1:0] tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input int req_stall, input int wb_stall,
                         input bit chk_lat);
      int k, fire, exp_lat;
      bit moved, hold_bad;
      logic [31:0] hd;
      req_en = (req_stall == 0);
      wb_rdy = (wb_stall == 0);
      @(negedge clk);
      check({name, ":op_rdy_idle"}, op_rdy, 64'd1);
      op_val = 1'b1; op_fn = fn; op_sel = sel; op_tag = tag; op_a = a; op_b = b;
      @(negedge clk);
      op_val = 1'b0; op_a = $urandom; op_b = $urandom; op_fn = ~fn; op_sel = ~sel; op_tag = ~tag;
      k = 1; fire = 0; moved = 1'b0;
      while (!wb_val && k < 300) begin
         if (k == req_stall + 1) req_en = 1'b1;
         #1;
         if (divreq_val && (divreq_msg_a !== a || divreq_msg_b !== b || divreq_msg_fn !== fn))
            moved = 1'b1;
         if (divreq_val && divreq_rdy && fire == 0) fire = k;
         @(negedge clk);
         k++;
      end
      req_en = 1'b1;
      check({name, ":wb_val_seen"}, wb_val, 64'd1);
      check({name, ":wb_data"}, wb_data, exp_data);
      check({name, ":wb_tag"}, wb_tag, tag);
      exp_lat = (DZ && b == 32'd0) ? 1 : 35 + req_stall;
      if (chk_lat) check({name, ":latency"}, k, exp_lat);
      if (DZ && b == 32'd0) begin
         check({name, ":no_divreq"}, fire, 64'd0);
      end else if (req_stall > 0) begin
         check({name, ":fire_cycle"}, fire, req_stall + 1);
         check({name, ":msg_stable"}, moved, 64'd0);
      end
      if (wb_stall > 0) begin
         hd = wb_data;
         hold_bad = 1'b0;
         repeat (wb_stall) begin
            @(negedge clk);
            if (!wb_val || op_rdy || divresp_rdy || wb_data !== hd || wb_tag !== tag)
               hold_bad = 1'b1;
         end
         check({name, ":wb_hold"}, hold_bad, 64'd0);
      end
      wb_rdy = 1'b1;
      @(negedge clk);
      check({name, ":back_idle"}, {op_rdy, wb_val}, 64'd2);
   endtask

   typedef struct {
      logic             fn;
      logic             sel;
      logic [TAG_W-1:0] tag;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [31:0]      exp;
      int               req_stall;
      int               wb_stall;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b0, 1'b0, 5'd3,  32'd100,         32'd7,           32'd14,          0, 0};
      tbl[1] = '{1'b1, 1'b0, 5'd5,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   0, 0};
      tbl[2] = '{1'b1, 1'b1, 5'd6,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   0, 0};
      tbl[3] = '{1'b0, 1'b1, 5'd9,  32'd100,         32'd7,           32'd2,           4, 0};
      tbl[4] = '{1'b0, 1'b0, 5'd12, 32'd1000,        32'd10,          32'd100,         0, 6};
      tbl[5] = '{1'b0, 1'b0, 5'd7,  32'h0000_1234,   32'd0,           32'hFFFF_FFFF,   0, 0};
      tbl[6] = '{1'b1, 1'b1, 5'd8,  32'h0000_1234,   32'd0,           32'h0000_1234,   0, 0};
      tbl[7] = '{1'b1, 1'b0, 5'd2,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   0, 0};

      reset = 1'b0; op_val = 1'b0; op_fn = 1'b0; op_sel = 1'b0; op_tag = '0;
      op_a = 32'd0; op_b = 32'd0; wb_rdy = 1'b1;
      repeat (2) @(negedge clk);
      check("rst:op_rdy", op_rdy, 64'd1);
      check("rst:valids", {divreq_val, divresp_rdy, wb_val}, 64'd0);
      check("rst:wb", {wb_tag, wb_data}, 64'd0);
      check("rst:msg", {divreq_msg_fn, divreq_msg_a, divreq_msg_b}, 64'd0);
      reset = 1'b1;

      for (int i = 0; i < 8; i++)
         run_op($sformatf("vec%0d", i), tbl[i].fn, tbl[i].sel, tbl[i].tag, tbl[i].a, tbl[i].b,
                tbl[i].exp, tbl[i].req_stall, tbl[i].wb_stall, 1'b1);

      // Reset pulsed during WAIT: immediate reset values, stale response must not be written back
      @(negedge clk);
      op_val = 1'b1; op_fn = 1'b0; op_sel = 1'b0; op_tag = 5'd17; op_a = 32'd50; op_b = 32'd5;
      @(negedge clk);
      op_val = 1'b0;
      repeat (10) @(negedge clk);
      check("midrst:in_wait", {divresp_rdy, divreq_val, wb_val}, 64'd4);
      reset = 1'b0;
      #1;
      check("midrst:op_rdy", op_rdy, 64'd1);
      check("midrst:valids", {divreq_val, divresp_rdy, wb_val}, 64'd0);
      check("midrst:wb", {wb_tag, wb_data}, 64'd0);
      check("midrst:msg", {divreq_msg_fn, divreq_msg_a, divreq_msg_b}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      run_op("recover", 1'b0, 1'b0, 5'd4, 32'd9, 32'd3, 32'd3, 0, 0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         logic fn, sel;
         logic [TAG_W-1:0] tag;
         logic [31:0] a, b;
         logic [63:0] r;
         int mode;
         fn = 1'($urandom_range(0, 1));
         sel = 1'($urandom_range(0, 1));
         tag = TAG_W'($urandom);
         a = $urandom;
         mode = $urandom_range(0, 3);
         if (mode == 0) b = 32'd0;
         else if (mode == 1) b = $urandom_range(1, 20);
         else if (mode == 2) b = -($urandom_range(1, 20));
         else b = $urandom;
         r = div_ref(fn, a, b);
         run_op($sformatf("rnd%0d", i), fn, sel, tag, a, b, sel ? r[63:32] : r[31:0],
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
